// File: rtl/regfile_writeback_queue.sv
// Serialises ALU and load write-backs into the register file's single write port via an in-order FIFO.
// A request accepted at edge N commits at edge N+1 at the earliest; readies come from registered occupancy only.
module regfile_writeback_queue #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32,
  parameter int RW    = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     alu_valid,
  output logic                     alu_ready,
  input  logic [RW-1:0]            alu_rd,
  input  logic [XLEN-1:0]          alu_data,
  input  logic                     mem_valid,
  output logic                     mem_ready,
  input  logic [RW-1:0]            mem_rd,
  input  logic [XLEN-1:0]          mem_data,
  output logic                     regWrite,
  output logic [RW-1:0]            Writereg,
  output logic [XLEN-1:0]          Writedata,
  input  logic [RW-1:0]            lk_reg1,
  input  logic [RW-1:0]            lk_reg2,
  output logic                     lk_hit1,
  output logic                     lk_hit2,
  output logic [XLEN-1:0]          lk_data1,
  output logic [XLEN-1:0]          lk_data2,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [RW-1:0]   rd_q   [DEPTH];
  logic [XLEN-1:0] data_q [DEPTH];
  logic [PW-1:0]   rp_q, rp_d, wp_q, wp_d, mem_slot;
  logic [CW-1:0]   count_q, count_d, free;
  logic            alu_en, mem_en, deq;

  assign free      = CW'(DEPTH) - count_q;
  assign alu_ready = (free != '0);
  assign mem_ready = (free >= CW'(2));

  // x0 requests complete the handshake but never occupy a slot
  assign alu_en   = alu_valid && alu_ready && (alu_rd != '0);
  assign mem_en   = mem_valid && mem_ready && (mem_rd != '0);
  assign mem_slot = wp_q + PW'(alu_en);
  assign deq      = (count_q != '0);

  assign rp_d    = rp_q + PW'(deq);
  assign wp_d    = wp_q + PW'(alu_en) + PW'(mem_en);
  assign count_d = count_q + CW'(alu_en) + CW'(mem_en) - CW'(deq);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rp_q    <= '0;
      wp_q    <= '0;
      count_q <= '0;
    end else begin
      rp_q    <= rp_d;
      wp_q    <= wp_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (alu_en) begin
      rd_q[wp_q]   <= alu_rd;
      data_q[wp_q] <= alu_data;
    end
    if (mem_en) begin
      rd_q[mem_slot]   <= mem_rd;
      data_q[mem_slot] <= mem_data;
    end
  end

  assign count     = count_q;
  assign empty     = (count_q == '0);
  assign full      = (count_q == CW'(DEPTH));
  assign regWrite  = !empty;
  assign Writereg  = empty ? '0 : rd_q[rp_q];
  assign Writedata = empty ? '0 : data_q[rp_q];

  // Walk oldest to youngest so the last match left standing is the youngest
  always_comb begin
    logic [PW-1:0] idx;
    idx      = '0;
    lk_hit1  = 1'b0;
    lk_hit2  = 1'b0;
    lk_data1 = '0;
    lk_data2 = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rp_q + PW'(i);
      if (CW'(i) < count_q) begin
        if ((lk_reg1 != '0) && (rd_q[idx] == lk_reg1)) begin
          lk_hit1  = 1'b1;
          lk_data1 = data_q[idx];
        end
        if ((lk_reg2 != '0) && (rd_q[idx] == lk_reg2)) begin
          lk_hit2  = 1'b1;
          lk_data2 = data_q[idx];
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_writeback_queue.sv
// Randomised and directed bench for regfile_writeback_queue against a queue-based reference model.
module tb_regfile_writeback_queue;

  localparam int DEPTH = 4;
  localparam int XLEN  = 32;
  localparam int RW    = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic            alu_valid, mem_valid;
  logic            alu_ready, mem_ready;
  logic [RW-1:0]   alu_rd, mem_rd, lk_reg1, lk_reg2;
  logic [XLEN-1:0] alu_data, mem_data;
  logic            regWrite;
  logic [RW-1:0]   Writereg;
  logic [XLEN-1:0] Writedata;
  logic            lk_hit1, lk_hit2;
  logic [XLEN-1:0] lk_data1, lk_data2;
  logic [$clog2(DEPTH):0] count;
  logic            empty, full;

  always #5 clk = ~clk;

  regfile_writeback_queue #(.DEPTH(DEPTH), .XLEN(XLEN), .RW(RW)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
    .regWrite(regWrite), .Writereg(Writereg), .Writedata(Writedata),
    .lk_reg1(lk_reg1), .lk_reg2(lk_reg2),
    .lk_hit1(lk_hit1), .lk_hit2(lk_hit2), .lk_data1(lk_data1), .lk_data2(lk_data2),
    .count(count), .empty(empty), .full(full)
  );

  typedef struct {
    logic [RW-1:0]   rd;
    logic [XLEN-1:0] data;
  } ent_t;

  ent_t mq[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [XLEN:0] model_lookup(input logic [RW-1:0] r);
    logic [XLEN:0] res;
    res = '0;
    if (r != '0)
      foreach (mq[i])
        if (mq[i].rd == r) res = {1'b1, mq[i].data};
    return res;
  endfunction

  task automatic compare_model();
    logic [XLEN:0] l1, l2;
    int sz;
    sz = mq.size();
    l1 = model_lookup(lk_reg1);
    l2 = model_lookup(lk_reg2);
    chk("regWrite",  32'(regWrite),  32'(sz > 0));
    chk("Writereg",  32'(Writereg),  sz > 0 ? 32'(mq[0].rd) : 32'd0);
    chk("Writedata", Writedata,      sz > 0 ? mq[0].data : 32'd0);
    chk("count",     32'(count),     32'(sz));
    chk("empty",     32'(empty),     32'(sz == 0));
    chk("full",      32'(full),      32'(sz == DEPTH));
    chk("alu_ready", 32'(alu_ready), 32'((DEPTH - sz) >= 1));
    chk("mem_ready", 32'(mem_ready), 32'((DEPTH - sz) >= 2));
    chk("lk_hit1",   32'(lk_hit1),   32'(l1[XLEN]));
    chk("lk_data1",  lk_data1,       l1[XLEN-1:0]);
    chk("lk_hit2",   32'(lk_hit2),   32'(l2[XLEN]));
    chk("lk_data2",  lk_data2,       l2[XLEN-1:0]);
  endtask

  // Called at a falling edge; returns at the next falling edge with the model advanced
  task automatic step(input logic av, input logic [RW-1:0] ard, input logic [XLEN-1:0] adat,
                      input logic mv, input logic [RW-1:0] mrd, input logic [XLEN-1:0] mdat,
                      input logic [RW-1:0] l1, input logic [RW-1:0] l2);
    int  free;
    bit  a_acc, m_acc;
    alu_valid = av; alu_rd = ard; alu_data = adat;
    mem_valid = mv; mem_rd = mrd; mem_data = mdat;
    lk_reg1 = l1; lk_reg2 = l2;
    #1;
    compare_model();
    free  = DEPTH - mq.size();
    a_acc = av && (free >= 1);
    m_acc = mv && (free >= 2);
    @(posedge clk);
    if (mq.size() > 0) void'(mq.pop_front());
    if (a_acc && ard != '0) mq.push_back('{rd: ard, data: adat});
    if (m_acc && mrd != '0) mq.push_back('{rd: mrd, data: mdat});
    @(negedge clk);
  endtask

  task automatic idle(input logic [RW-1:0] l1, input logic [RW-1:0] l2);
    step(1'b0, '0, '0, 1'b0, '0, '0, l1, l2);
  endtask

  initial begin
    rst = 1'b0;
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
    lk_reg1 = '0; lk_reg2 = '0;
    #3;
    chk("rst_regWrite", 32'(regWrite), 32'd0);
    chk("rst_empty",    32'(empty),    32'd1);
    chk("rst_full",     32'(full),     32'd0);
    chk("rst_count",    32'(count),    32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Single ALU write, visible after one edge, committed after the next
    step(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, '0, '0, '0, '0);
    chk("t1_regWrite",  32'(regWrite), 32'd1);
    chk("t1_Writereg",  32'(Writereg), 32'd5);
    chk("t1_Writedata", Writedata,     32'hDEADBEEF);
    chk("t1_count",     32'(count),    32'd1);
    idle('0, '0);
    chk("t1_drain_rw",  32'(regWrite), 32'd0);
    chk("t1_drain_emp", 32'(empty),    32'd1);

    // Same-cycle pair to one register: ALU older, youngest wins lookup
    step(1'b1, 5'd3, 32'h11, 1'b1, 5'd3, 32'h22, 5'd3, '0);
    chk("t2_head",  Writedata,       32'h11);
    chk("t2_hit",   32'(lk_hit1),    32'd1);
    chk("t2_data",  lk_data1,        32'h22);
    idle(5'd3, '0);
    chk("t2_second", Writedata,      32'h22);
    idle('0, '0);

    // x0 request is accepted but only the rd=7 entry lands
    step(1'b1, 5'd0, 32'h99, 1'b1, 5'd7, 32'h77, 5'd0, 5'd7);
    chk("t3_count", 32'(count),    32'd1);
    chk("t3_wreg",  32'(Writereg), 32'd7);
    chk("t3_x0hit", 32'(lk_hit1),  32'd0);
    idle('0, '0);

    // Lookup miss and hit with rd=4 and rd=9 pending
    step(1'b1, 5'd4, 32'hA4, 1'b1, 5'd9, 32'hB9, 5'd9, 5'd10);
    chk("t4_hit1",  32'(lk_hit1), 32'd1);
    chk("t4_data1", lk_data1,     32'hB9);
    chk("t4_hit2",  32'(lk_hit2), 32'd0);
    chk("t4_data2", lk_data2,     32'd0);
    idle('0, '0);
    idle('0, '0);

    // Saturate both producers
    for (int i = 0; i < 12; i++)
      step(1'b1, 5'(1 + (i % 31)), $urandom, 1'b1, 5'(2 + (i % 29)), $urandom, 5'(i % 8), 5'((i + 3) % 8));

    // Random traffic
    for (int i = 0; i < 1500; i++)
      step(($urandom % 4) != 0, 5'($urandom % 8), $urandom,
           ($urandom % 4) != 0, 5'($urandom % 8), $urandom,
           5'($urandom % 8), 5'($urandom % 8));
    for (int i = 0; i < 5; i++) idle('0, '0);

    // Asynchronous reset with three entries pending
    step(1'b1, 5'd1, 32'hA1, 1'b1, 5'd2, 32'hA2, '0, '0);
    step(1'b1, 5'd6, 32'hB6, 1'b1, 5'd8, 32'hB8, 5'd8, '0);
    chk("t5_count3", 32'(count),    32'd3);
    chk("t5_head",   32'(Writereg), 32'd2);
    alu_valid = 1'b0; mem_valid = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    mq.delete();
    chk("t5_rst_rw",    32'(regWrite),  32'd0);
    chk("t5_rst_wreg",  32'(Writereg),  32'd0);
    chk("t5_rst_wdata", Writedata,      32'd0);
    chk("t5_rst_count", 32'(count),     32'd0);
    chk("t5_rst_empty", 32'(empty),     32'd1);
    chk("t5_rst_hit",   32'(lk_hit1),   32'd0);
    chk("t5_rst_data",  lk_data1,       32'd0);
    @(negedge clk);
    rst = 1'b1;
    step(1'b1, 5'd12, 32'h1234, 1'b0, '0, '0, 5'd12, '0);
    chk("t5_post_wreg",  32'(Writereg), 32'd12);
    chk("t5_post_wdata", Writedata,     32'h1234);
    idle('0, '0);
    chk("t5_post_empty", 32'(empty),    32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
